dmem_arbiter: RTL and testbench

- Shares the single-port 256x16 data memory between two requesters: port 0 is the CPU load/store unit (LW/SW) and port 1 is the debug/loader.
- Arbitration is round-robin with a bounded burst length. At most one access is issued per cycle.
- Reads are pipelined with 1-cycle memory latency, and read data is routed back to the owning port.
- Sits between the CPU datapath and the data memory macro.

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 101 ++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the environment that drives requests.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [DW-1:0] p1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of a single-port data memory.
// One access issues per cycle; read data returns the next cycle to the port that issued it.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  localparam int            RW      = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_BURST);
  localparam logic [RW-1:0] RUN_ONE = RW'(1);

  logic [1:0]    req;
  logic [1:0]    we;
  logic [1:0]    gnt;
  logic [1:0]    rvalid;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];

  logic          owner_q, owner_d;
  logic [RW-1:0] run_q, run_d;
  logic          tag_valid_q, tag_valid_d;
  logic          tag_port_q, tag_port_d;

  logic          issue;
  logic          sel_port;

  assign req      = {bus.p1_req, bus.p0_req};
  assign we       = {bus.p1_we, bus.p0_we};
  assign addr[0]  = bus.p0_addr;
  assign addr[1]  = bus.p1_addr;
  assign wdata[0] = bus.p0_wdata;
  assign wdata[1] = bus.p1_wdata;

  // Nothing issues while reset is held, whatever the requesters do.
  assign issue = rst_n & (|req);

  always_comb begin
    sel_port = 1'b0;
    if (&req) begin
      sel_port = (run_q < RUN_MAX) ? owner_q : ~owner_q;
    end else begin
      sel_port = req[1];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      assign gnt[gi]    = issue & (sel_port == 1'(gi));
      // Gated by rst_n so a read tagged just before reset never surfaces.
      assign rvalid[gi] = rst_n & tag_valid_q & (tag_port_q == 1'(gi));
    end
  endgenerate

  assign bus.p0_gnt    = gnt[0];
  assign bus.p1_gnt    = gnt[1];
  assign bus.p0_rvalid = rvalid[0];
  assign bus.p1_rvalid = rvalid[1];
  assign bus.p0_rdata  = bus.mem_rdata;
  assign bus.p1_rdata  = bus.mem_rdata;

  assign bus.mem_en    = issue;
  assign bus.mem_we    = we[sel_port];
  assign bus.mem_addr  = addr[sel_port];
  assign bus.mem_wdata = wdata[sel_port];

  always_comb begin
    owner_d     = owner_q;
    run_d       = run_q;
    tag_valid_d = issue & ~we[sel_port];
    tag_port_d  = sel_port;
    if (issue) begin
      if (sel_port == owner_q) begin
        run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_ONE;
      end else begin
        owner_d = sel_port;
        run_d   = RUN_ONE;
      end
    end
  end

  // Reset leaves port 1 as a saturated owner so port 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q     <= 1'b1;
      run_q       <= RUN_MAX;
      tag_valid_q <= 1'b0;
      tag_port_q  <= 1'b0;
    end else begin
      owner_q     <= owner_d;
      run_q       <= run_d;
      tag_valid_q <= tag_valid_d;
      tag_port_q  <= tag_port_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter: queued requesters, a memory macro model and a
// transaction-level reference of the round-robin/burst rules.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 4;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 'h10) ? 16'hBEEF : 16'(i + 'h100);
  endfunction

  // Memory macro: one-cycle read latency, writes land at the edge.
  logic [DW-1:0] mem_arr [256];
  bit            mem_inited = 1'b0;
  always @(posedge clk) begin
    if (!mem_inited) begin
      for (int i = 0; i < 256; i++) mem_arr[i] <= init_word(i);
      mem_inited <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata <= mem_arr[bus.mem_addr];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [DW-1:0] ref_mem [256];
  int            owner_m   = 1;
  int            streak_m  = MB;
  bit            pend_v    = 1'b0;
  int            pend_port = 0;
  logic [DW-1:0] pend_data = '0;

  // Requester state
  txn_t q0[$];
  txn_t q1[$];
  bit   hold [2];
  txn_t cur  [2];
  int   pct  [2];
  bit   rst_val;

  function automatic txn_t mk(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.wdata = d;
    return t;
  endfunction

  task automatic do_cycle();
    int g;
    bit ev0, ev1;
    if (!hold[0] && q0.size() > 0 && $urandom_range(99) < pct[0]) begin
      hold[0] = 1'b1; cur[0] = q0.pop_front();
    end
    if (!hold[1] && q1.size() > 0 && $urandom_range(99) < pct[1]) begin
      hold[1] = 1'b1; cur[1] = q1.pop_front();
    end
    bus.p0_req = hold[0]; bus.p0_we = cur[0].we; bus.p0_addr = cur[0].addr; bus.p0_wdata = cur[0].wdata;
    bus.p1_req = hold[1]; bus.p1_we = cur[1].we; bus.p1_addr = cur[1].addr; bus.p1_wdata = cur[1].wdata;
    rst_n = rst_val;
    #1;
    if (!rst_val || (!hold[0] && !hold[1])) g = -1;
    else if (hold[0] && !hold[1])           g = 0;
    else if (hold[1] && !hold[0])           g = 1;
    else                                    g = (streak_m < MB) ? owner_m : 1 - owner_m;

    check("p0_gnt", 32'(bus.p0_gnt), 32'(g == 0));
    check("p1_gnt", 32'(bus.p1_gnt), 32'(g == 1));
    check("mem_en", 32'(bus.mem_en), 32'(g >= 0));
    if (g >= 0) begin
      check("mem_we", 32'(bus.mem_we), 32'(cur[g].we));
      check("mem_addr", 32'(bus.mem_addr), 32'(cur[g].addr));
      if (cur[g].we) check("mem_wdata", 32'(bus.mem_wdata), 32'(cur[g].wdata));
    end
    ev0 = rst_val && pend_v && (pend_port == 0);
    ev1 = rst_val && pend_v && (pend_port == 1);
    check("p0_rvalid", 32'(bus.p0_rvalid), 32'(ev0));
    check("p1_rvalid", 32'(bus.p1_rvalid), 32'(ev1));
    if (ev0) check("p0_rdata", 32'(bus.p0_rdata), 32'(pend_data));
    if (ev1) check("p1_rdata", 32'(bus.p1_rdata), 32'(pend_data));

    @(posedge clk);
    if (!rst_val) begin
      owner_m = 1; streak_m = MB; pend_v = 1'b0;
    end else begin
      pend_v = 1'b0;
      if (g >= 0) begin
        if (cur[g].we) begin
          ref_mem[cur[g].addr] = cur[g].wdata;
          $display("[TB] t=%0t p%0d WR addr=0x%02h data=0x%04h", $time, g, cur[g].addr, cur[g].wdata);
        end else begin
          pend_v = 1'b1; pend_port = g; pend_data = ref_mem[cur[g].addr];
          $display("[TB] t=%0t p%0d RD addr=0x%02h data=0x%04h", $time, g, cur[g].addr, pend_data);
        end
        if (g == owner_m) streak_m = (streak_m < MB) ? streak_m + 1 : MB;
        else begin owner_m = g; streak_m = 1; end
        hold[g] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || hold[0] || hold[1] || pend_v) && n < max_cycles) begin
      do_cycle();
      n++;
    end
    check({tag, "_drain"}, 32'(n < max_cycles), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    hold[0] = 1'b0; hold[1] = 1'b0;
    cur[0] = '0; cur[1] = '0;
    pct[0] = 100; pct[1] = 100;

    rst_val = 1'b0;
    do_cycle();
    do_cycle();
    rst_val = 1'b1;

    // Single p0 read of a preloaded word
    q0.push_back(mk(1'b0, 8'h10, 16'h0));
    drain("rd10", 20);

    // p1 write then p0 read-back
    q1.push_back(mk(1'b1, 8'h20, 16'h1234));
    drain("wr20", 20);
    q0.push_back(mk(1'b0, 8'h20, 16'h0));
    drain("rd20", 20);

    // Alternating back-to-back reads
    q0.push_back(mk(1'b0, 8'h01, 16'h0));
    do_cycle();
    q1.push_back(mk(1'b0, 8'h02, 16'h0));
    do_cycle();
    q0.push_back(mk(1'b0, 8'h03, 16'h0));
    do_cycle();
    drain("alt", 20);

    // p1 alone for 10 cycles, then p0 joins
    pct[0] = 0;
    for (int i = 0; i < 16; i++) q1.push_back(mk(1'b0, 8'(i + 'h40), 16'h0));
    for (int i = 0; i < 8; i++)  q0.push_back(mk(1'b0, 8'(i + 'h60), 16'h0));
    repeat (10) do_cycle();
    pct[0] = 100;
    drain("join", 100);

    // Read then reset; both ports contend from reset release
    q0.push_back(mk(1'b0, 8'h33, 16'h0));
    do_cycle();
    rst_val = 1'b0;
    for (int i = 0; i < 12; i++) begin
      q0.push_back(mk(1'b0, 8'(i), 16'h0));
      q1.push_back(mk(1'b0, 8'(i + 'h80), 16'h0));
    end
    do_cycle();
    do_cycle();
    rst_val = 1'b1;
    drain("rst", 100);

    // Random mixed traffic
    for (int r = 0; r < 8; r++) begin
      pct[0] = $urandom_range(10, 100);
      pct[1] = $urandom_range(10, 100);
      for (int i = 0; i < 40; i++) begin
        q0.push_back(mk(1'($urandom_range(1)), 8'($urandom_range(31)), 16'($urandom)));
        q1.push_back(mk(1'($urandom_range(1)), 8'($urandom_range(31)), 16'($urandom)));
      end
      drain("rand", 1500);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
